// File: rtl/led_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : led_pulse_stretcher
// Purpose  : Stretches short event strobes or levels into human-visible LED
//            blinks. Every blink has an on-time of exactly ON_CYCLES clocks
//            and is followed by an off-gap of at least OFF_CYCLES clocks.
//            Events that arrive while a blink is in progress are queued in a
//            saturating counter, so each one later shows as its own blink.
// Ports    : i_Clk      - system clock
//            i_Rst_L    - asynchronous active-low reset
//            i_Event    - event input; each rising edge is one event
//            i_Clr_Ovf  - synchronous clear of o_Overflow
//            o_LED      - stretched LED drive, active high, registered
//            o_Busy     - high while a blink or its off-gap is in progress
//            o_Pending  - number of queued, not-yet-displayed events
//            o_Overflow - sticky flag: an event was dropped (queue full)
// Revision : 1.0 - initial release
// ============================================================================
module led_pulse_stretcher #(
  parameter int ON_CYCLES  = 2500000,
  parameter int OFF_CYCLES = 1250000,
  parameter int PEND_MAX   = 7,
  parameter int PEND_W     = 3
) (
  input  logic              i_Clk,
  input  logic              i_Rst_L,
  input  logic              i_Event,
  input  logic              i_Clr_Ovf,
  output logic              o_LED,
  output logic              o_Busy,
  output logic [PEND_W-1:0] o_Pending,
  output logic              o_Overflow
);

  localparam logic [31:0]       C_ON_LOAD  = 32'(ON_CYCLES - 1);
  localparam logic [31:0]       C_OFF_LOAD = 32'(OFF_CYCLES - 1);
  localparam logic [PEND_W-1:0] C_PEND_MAX = PEND_W'(PEND_MAX);
  localparam logic [PEND_W-1:0] C_PEND_ONE = PEND_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                prev_q;
  logic                led_q, led_d;
  logic                busy_q, busy_d;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                ovf_q, ovf_d;

  logic                w_edge;
  logic                w_ovf_set;
  logic [PEND_W:0]     w_pend_sum;

  // i_Event is already synchronous to i_Clk; a held level yields one event.
  assign w_edge = i_Event & ~prev_q;

  // One bit wider than the queue so pending + edge cannot wrap at the
  // GAP terminal cycle, where an arriving edge and a dequeue cancel out.
  assign w_pend_sum = {1'b0, pend_q} + {{PEND_W{1'b0}}, w_edge};

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      cnt_q   <= 32'd0;
      prev_q  <= 1'b0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prev_q  <= i_Event;
      led_q   <= led_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    led_d     = led_q;
    busy_d    = busy_q;
    pend_d    = pend_q;
    w_ovf_set = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (w_edge) begin
          state_d = S_ON;
          cnt_d   = C_ON_LOAD;
          led_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_ON: begin
        if (w_edge) begin
          if (pend_q < C_PEND_MAX) pend_d = pend_q + C_PEND_ONE;
          else                     w_ovf_set = 1'b1;
        end
        if (cnt_q == 32'd0) begin
          state_d = S_GAP;
          cnt_d   = C_OFF_LOAD;
          led_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end

      S_GAP: begin
        if (cnt_q == 32'd0) begin
          // Terminal cycle: an edge arriving now is counted together with
          // the queue, so it can never overflow here.
          if (w_pend_sum != '0) begin
            state_d = S_ON;
            cnt_d   = C_ON_LOAD;
            led_d   = 1'b1;
            pend_d  = PEND_W'(w_pend_sum - {{PEND_W{1'b0}}, 1'b1});
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 32'd1;
          if (w_edge) begin
            if (pend_q < C_PEND_MAX) pend_d = pend_q + C_PEND_ONE;
            else                     w_ovf_set = 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        led_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase

    // A new drop wins over a clear issued in the same cycle.
    ovf_d = w_ovf_set | (ovf_q & ~i_Clr_Ovf);
  end

  assign o_LED      = led_q;
  assign o_Busy     = busy_q;
  assign o_Pending  = pend_q;
  assign o_Overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_led_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_pulse_stretcher
// Purpose  : Self-checking bench for led_pulse_stretcher with ON_CYCLES=4,
//            OFF_CYCLES=3, PEND_MAX=3, PEND_W=2. Row k of each vector table
//            holds the inputs driven during cycle k and the outputs expected
//            in cycle k+1 (just after the clock edge that ends cycle k).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_pulse_stretcher;

  localparam int ON_C  = 4;
  localparam int OFF_C = 3;
  localparam int PMAX  = 3;
  localparam int PW    = 2;
  localparam int PER   = ON_C + OFF_C;

  logic          clk;
  logic          rst_n;
  logic          ev;
  logic          clr;
  logic          led;
  logic          busy;
  logic [PW-1:0] pend;
  logic          ovf;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic          ev;
    logic          clr;
    logic          led;
    logic          busy;
    logic [PW-1:0] pend;
    logic          ovf;
  } vec_t;

  vec_t vecs[$];

  led_pulse_stretcher #(
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .PEND_MAX   (PMAX),
    .PEND_W     (PW)
  ) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Event    (ev),
    .i_Clr_Ovf  (clr),
    .o_LED      (led),
    .o_Busy     (busy),
    .o_Pending  (pend),
    .o_Overflow (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int row, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s row %0d: got %0d, expected %0d", name, row, act, exp);
  endtask

  function automatic void add(input bit e, input bit c, input bit l, input bit b,
                              input int p, input bit o);
    vec_t v;
    v.ev = e; v.clr = c; v.led = l; v.busy = b; v.pend = PW'(p); v.ovf = o;
    vecs.push_back(v);
  endfunction

  function automatic bit in_rng(input int k, input int lo, input int hi);
    return (k >= lo) && (k <= hi);
  endfunction

  // Rows on which o_LED is expected high: n blinks of ON_C cycles with
  // period PER, the first showing in the row after the starting strobe.
  function automatic bit in_blink(input int k, input int first, input int n);
    for (int j = 0; j < n; j++)
      if (in_rng(k, first + PER*j, first + PER*j + ON_C - 1)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    ev    = 1'b0;
    clr   = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_vectors(input string tname);
    for (int i = 0; i < vecs.size(); i++) begin
      ev  = vecs[i].ev;
      clr = vecs[i].clr;
      @(posedge clk);
      #1;
      chk({tname, ".led"},  i, int'(led),  int'(vecs[i].led));
      chk({tname, ".busy"}, i, int'(busy), int'(vecs[i].busy));
      chk({tname, ".pend"}, i, int'(pend), int'(vecs[i].pend));
      chk({tname, ".ovf"},  i, int'(ovf),  int'(vecs[i].ovf));
    end
    vecs.delete();
    ev  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic build_single();
    for (int k = 0; k < 20; k++)
      add(k == 10, 1'b0, in_rng(k, 10, 13), in_rng(k, 10, 16), 0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    ev    = 1'b0;
    clr   = 1'b0;
    #2;
    chk("reset.led",  0, int'(led),  0);
    chk("reset.busy", 0, int'(busy), 0);
    chk("reset.pend", 0, int'(pend), 0);
    chk("reset.ovf",  0, int'(ovf),  0);

    // 1: single strobe -> one 4-cycle blink, idle after the 3-cycle gap
    do_reset();
    build_single();
    run_vectors("t1_single");

    // 2: level held for 50 cycles -> exactly one blink, nothing queued
    do_reset();
    for (int k = 0; k < 70; k++)
      add(in_rng(k, 10, 59), 1'b0, in_rng(k, 10, 13), in_rng(k, 10, 16), 0, 1'b0);
    run_vectors("t2_level");

    // 3: strobes at 10, 12, 14 -> three blinks with period 7
    do_reset();
    for (int k = 0; k < 36; k++) begin
      int p;
      p = in_rng(k, 12, 13) ? 1 : in_rng(k, 14, 16) ? 2 : in_rng(k, 17, 23) ? 1 : 0;
      add(k == 10 || k == 12 || k == 14, 1'b0, in_blink(k, 10, 3),
          in_rng(k, 10, 30), p, 1'b0);
    end
    run_vectors("t3_queue");

    // 4: fill queue, drop one (clear in the same cycle loses), clear later
    do_reset();
    for (int k = 0; k < 50; k++) begin
      int p;
      p = in_rng(k, 12, 13) ? 1 : in_rng(k, 14, 15) ? 2 : (k == 16) ? 3 :
          in_rng(k, 17, 18) ? 2 : in_rng(k, 19, 23) ? 3 : in_rng(k, 24, 30) ? 2 :
          in_rng(k, 31, 37) ? 1 : 0;
      add(k == 10 || k == 12 || k == 14 || k == 16 || k == 19 || k == 21,
          k == 21 || k == 23, in_blink(k, 10, 5), in_rng(k, 10, 44), p,
          k == 21 || k == 22);
    end
    run_vectors("t4_ovf");

    // 5a: strobe exactly on the GAP terminal cycle with an empty queue
    do_reset();
    for (int k = 0; k < 30; k++)
      add(k == 10 || k == 17, 1'b0, in_blink(k, 10, 2), in_rng(k, 10, 23), 0, 1'b0);
    run_vectors("t5a_term");

    // 5b: strobe on the GAP terminal cycle with a full queue -> no overflow
    do_reset();
    for (int k = 0; k < 56; k++) begin
      int p;
      p = in_rng(k, 12, 13) ? 1 : in_rng(k, 14, 15) ? 2 : (k == 16) ? 3 :
          in_rng(k, 17, 18) ? 2 : in_rng(k, 19, 30) ? 3 : in_rng(k, 31, 37) ? 2 :
          in_rng(k, 38, 44) ? 1 : 0;
      add(k == 10 || k == 12 || k == 14 || k == 16 || k == 19 || k == 24, 1'b0,
          in_blink(k, 10, 6), in_rng(k, 10, 51), p, 1'b0);
    end
    run_vectors("t5b_full");

    // 6: asynchronous reset in the middle of a blink with a full queue
    do_reset();
    for (int k = 0; k <= 20; k++) begin
      ev = (k == 10 || k == 12 || k == 14 || k == 16 || k == 18 || k == 20);
      @(posedge clk);
      #1;
    end
    ev = 1'b0;
    chk("t6_pre.led",  21, int'(led),  1);
    chk("t6_pre.busy", 21, int'(busy), 1);
    chk("t6_pre.pend", 21, int'(pend), 3);
    chk("t6_pre.ovf",  21, int'(ovf),  1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst.led",  21, int'(led),  0);
    chk("t6_rst.busy", 21, int'(busy), 0);
    chk("t6_rst.pend", 21, int'(pend), 0);
    chk("t6_rst.ovf",  21, int'(ovf),  0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    build_single();
    run_vectors("t6_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
